// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register for the 5-stage RV32 core.
// Pairs the fetch PC / PC+4 with the instruction word that the synchronous
// instruction memory returns one cycle later. A replay copy of that word
// covers decode stalls, and a NOP bubble is inserted on branch/jump flushes.
// Optional feature macro: IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_write,
  input  logic        IF_flush,
  input  logic [31:0] PC_in,
  input  logic [31:0] PCadd4_in,
  input  logic [31:0] IM_DO,
`ifdef IF_ID_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PCadd4,
  output logic [31:0] ID_inst,
  output logic        ID_valid
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcadd4_q, pcadd4_d;
  logic [31:0] hold_q, hold_d;
  logic        valid_q, valid_d;

  // Next-state selection with priority flush > write > stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pcadd4_d = pcadd4_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    if (IF_flush) begin
      // The PC still tracks fetch so the bubble carries the squashed address.
      state_d  = BUBBLE;
      valid_d  = 1'b0;
      pc_d     = PC_in;
      pcadd4_d = PCadd4_in;
    end else if (IF_ID_write) begin
      state_d  = RUN;
      valid_d  = 1'b1;
      pc_d     = PC_in;
      pcadd4_d = PCadd4_in;
    end else if (state_q == RUN) begin
      // IM_DO will move on next cycle, so snapshot the word now.
      hold_d  = IM_DO;
      state_d = HOLD;
    end
  end

  // Pipeline state register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BUBBLE;
      pc_q     <= RESET_PC;
      pcadd4_q <= RESET_PC + 32'd4;
      hold_q   <= NOP_INST;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pcadd4_q <= pcadd4_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
    end
  end

  // Instruction source depends on whether ID is live, replaying, or a bubble.
  always_comb begin
    ID_inst = NOP_INST;
    case (state_q)
      RUN:     ID_inst = IM_DO;
      HOLD:    ID_inst = hold_q;
      default: ID_inst = NOP_INST;
    endcase
  end

  assign ID_PC     = pc_q;
  assign ID_PCadd4 = pcadd4_q;
  assign ID_valid  = valid_q && (state_q != BUBBLE);

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (IF_flush)
      flush_cnt_d = sat_inc(flush_cnt_q);
    else if (!IF_ID_write)
      stall_cnt_d = sat_inc(stall_cnt_q);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed testbench for if_id_pipe: reset, streaming, stall replay,
// flush, flush during stall, single-cycle stall and reset mid-stall.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_ID_write;
  logic        IF_flush;
  logic [31:0] PC_in;
  logic [31:0] PCadd4_in;
  logic [31:0] IM_DO;
  logic [31:0] ID_PC;
  logic [31:0] ID_PCadd4;
  logic [31:0] ID_inst;
  logic        ID_valid;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .IF_ID_write (IF_ID_write),
    .IF_flush    (IF_flush),
    .PC_in       (PC_in),
    .PCadd4_in   (PCadd4_in),
    .IM_DO       (IM_DO),
`ifdef IF_ID_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .ID_PC       (ID_PC),
    .ID_PCadd4   (ID_PCadd4),
    .ID_inst     (ID_inst),
    .ID_valid    (ID_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the full ID-side view in one go.
  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic vld);
    chk({tag, ".pc"}, ID_PC, pc);
    chk({tag, ".pc4"}, ID_PCadd4, pc + 32'd4);
    chk({tag, ".inst"}, ID_inst, inst);
    chk({tag, ".valid"}, {31'd0, ID_valid}, {31'd0, vld});
  endtask

  // Apply controls for one edge, then present the IM word for the address
  // the memory latched at that edge; returns mid-cycle, ready to sample.
  task automatic cyc(input logic w, input logic f, input logic [31:0] pc,
                     input logic [31:0] im_after);
    IF_ID_write = w;
    IF_flush    = f;
    PC_in       = pc;
    PCadd4_in   = pc + 32'd4;
    @(posedge clk);
    #1 IM_DO = im_after;
    #1;
  endtask

  initial begin
    rst = 1'b1; IF_ID_write = 1'b0; IF_flush = 1'b0;
    PC_in = 32'h0; PCadd4_in = 32'h4; IM_DO = 32'h0;

    // Reset held for two edges, then released with a stall.
    @(posedge clk); @(posedge clk); #2;
    chk_id("rst_hold", 32'h0, 32'h13, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_id("rst_rel", 32'h0, 32'h13, 1'b0);

    // Streaming.
    cyc(1'b1, 1'b0, 32'h0, 32'hA0); chk_id("strm0", 32'h0, 32'hA0, 1'b1);
    cyc(1'b1, 1'b0, 32'h4, 32'hA4); chk_id("strm1", 32'h4, 32'hA4, 1'b1);
    cyc(1'b1, 1'b0, 32'h8, 32'hA8); chk_id("strm2", 32'h8, 32'hA8, 1'b1);

    // Stall replay: IM moves to 0xAC, then garbage.
    cyc(1'b0, 1'b0, 32'hC, 32'hAC);        chk_id("stall1", 32'h8, 32'hA8, 1'b1);
    cyc(1'b0, 1'b0, 32'hC, 32'hDEAD_BEEF); chk_id("stall2", 32'h8, 32'hA8, 1'b1);
    cyc(1'b0, 1'b0, 32'hC, 32'hDEAD_BEEF); chk_id("stall3", 32'h8, 32'hA8, 1'b1);
    IM_DO = 32'hAC;
    cyc(1'b1, 1'b0, 32'hC, 32'hAC);        chk_id("release", 32'hC, 32'hAC, 1'b1);

    // Flush while fetching 0x10, then resume at branch target 0x40.
    cyc(1'b1, 1'b1, 32'h10, 32'hB0); chk_id("flush", 32'h10, 32'h13, 1'b0);
    cyc(1'b1, 1'b0, 32'h40, 32'hC0); chk_id("target", 32'h40, 32'hC0, 1'b1);

    // Flush during HOLD; stale replay word must never appear.
    cyc(1'b0, 1'b0, 32'h44, 32'hC4); chk_id("fs_hold1", 32'h40, 32'hC0, 1'b1);
    cyc(1'b0, 1'b0, 32'h44, 32'hC4); chk_id("fs_hold2", 32'h40, 32'hC0, 1'b1);
    cyc(1'b0, 1'b1, 32'h44, 32'hC4); chk_id("fs_flush", 32'h44, 32'h13, 1'b0);
    cyc(1'b0, 1'b0, 32'h44, 32'hC4); chk_id("fs_bubst", 32'h44, 32'h13, 1'b0);
    cyc(1'b1, 1'b0, 32'h80, 32'hE0); chk_id("fs_resume", 32'h80, 32'hE0, 1'b1);

    // Single-cycle stall: held word for one cycle, then the next IM word.
    cyc(1'b0, 1'b0, 32'h84, 32'hE4); chk_id("s1_hold", 32'h80, 32'hE0, 1'b1);
    cyc(1'b1, 1'b0, 32'h84, 32'hE4); chk_id("s1_next", 32'h84, 32'hE4, 1'b1);

    // Enter HOLD, then reset mid-stall.
    cyc(1'b0, 1'b0, 32'h88, 32'hE8); chk_id("rm_hold", 32'h84, 32'hE4, 1'b1);
`ifdef IF_ID_PERF_EN
    // Stalls: release 1, replay 3, flush-test 3, single 1, this 1 = 9; flushes 2.
    chk("perf_stall", perf_stall_cnt, 32'd9);
    chk("perf_flush", perf_flush_cnt, 32'd2);
`endif
    rst = 1'b1;
    cyc(1'b1, 1'b1, 32'h88, 32'hE8); chk_id("rm_rst", 32'h0, 32'h13, 1'b0);
`ifdef IF_ID_PERF_EN
    chk("perf_stall0", perf_stall_cnt, 32'd0);
    chk("perf_flush0", perf_flush_cnt, 32'd0);
`endif
    rst = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 32'hA0); chk_id("post_rst", 32'h0, 32'hA0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- IF/ID pipeline register between the fetch stage and the decode stage of the 5-stage RV32 core.
- Captures the fetch-stage PC and PC+4 on each enabled edge, and pairs them with the instruction word returned one cycle later by the synchronous instruction memory.
- Handles decode stalls by holding a replay copy of the instruction word, and handles branch/jump flushes by inserting a NOP bubble.

Parameters:
- RESET_PC, 32'h0000_0000, value of ID_PC/ID_PCadd4 - 4 after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (ADDI x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- IF_ID_write  input  1  1 = advance register; 0 = stall (hold).
- IF_flush  input  1  1 = squash the instruction entering ID.
- PC_in  input  32  fetch-stage PC_out (address presented to IM this cycle).
- PCadd4_in  input  32  fetch-stage PC+4.
- IM_DO  input  32  IM read data; valid 1 cycle after its address.
- ID_PC  output  32  PC of the instruction in ID.
- ID_PCadd4  output  32  PC+4 of the instruction in ID.
- ID_inst  output  32  instruction word in ID.
- ID_valid  output  1  1 = ID holds a real instruction; 0 = bubble.

Behaviour:
- Registered state: pc_q, pcadd4_q, valid_q, hold_q[31:0], state (RUN, HOLD, BUBBLE).
- Reset (rst=1 at an edge) sets pc_q=RESET_PC, pcadd4_q=RESET_PC+4, valid_q=0, hold_q=NOP_INST, and state=BUBBLE.
  - Result after reset: ID_inst=NOP_INST and ID_valid=0.
  - rst overrides every other input, including mid-stall and mid-flush.
- ID_inst is combinational from state:
  - RUN: ID_inst=IM_DO.
  - HOLD: ID_inst=hold_q.
  - BUBBLE: ID_inst=NOP_INST.
- ID_valid = valid_q and (state != BUBBLE).
- Latency: PC_in is sampled at edge N and appears on ID_PC in cycle N+1, together with IM_DO for that address. Total: 1 cycle.
- Transition priority at each edge: rst > IF_flush > IF_ID_write.
- IF_flush=1 (IF_ID_write is don't-care):
  - state<=BUBBLE, valid_q<=0.
  - pc_q and pcadd4_q still load PC_in and PCadd4_in.
  - A flush during HOLD discards hold_q.
- IF_flush=0, IF_ID_write=1:
  - pc_q<=PC_in, pcadd4_q<=PCadd4_in, valid_q<=1, state<=RUN.
  - A pending HOLD is released; the next word comes from IM_DO.
- IF_flush=0, IF_ID_write=0 (stall):
  - pc_q, pcadd4_q and valid_q hold their values.
  - From RUN: hold_q<=IM_DO and state<=HOLD. This captures the word before IM_DO moves on.
  - From HOLD: hold_q and state are unchanged; the stall may last any number of cycles.
  - From BUBBLE: state stays BUBBLE and hold_q is unchanged.
- A single-cycle stall followed by IF_ID_write=1 presents the held word for exactly 1 cycle, then IM_DO. No instruction is duplicated or dropped.
- No arithmetic is performed; PCadd4_in is passed through as-is, and 32-bit wrap is upstream's responsibility.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- When defined, the block adds these output ports:
  - perf_stall_cnt [31:0]: number of edges with rst=0, IF_flush=0, IF_ID_write=0.
  - perf_flush_cnt [31:0]: number of edges with rst=0, IF_flush=1.
- Both counters:
  - are zeroed by rst;
  - saturate at 32'hFFFF_FFFF, with no wrap.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release with IF_ID_write=0.
  - Required: ID_inst=32'h0000_0013, ID_valid=0, ID_PC=0, ID_PCadd4=4.
- Streaming: IF_ID_write=1 with PC_in=0x0,0x4,0x8, and IM_DO returning 0xA0,0xA4,0xA8 one cycle later.
  - Required: ID_PC/ID_inst = (0x0,0xA0), (0x4,0xA4), (0x8,0xA8) in consecutive cycles, with ID_valid=1.
- Stall replay: with ID holding PC=0x8/inst=0xA8, drop IF_ID_write for 3 cycles while IM_DO changes to 0xAC, then to 0xDEAD_BEEF.
  - Required: ID_inst stays 0xA8 and ID_PC stays 0x8 for all 3 cycles.
  - On release, the next cycle shows 0xAC with PC=0xC.
- Flush: assert IF_flush=1 for 1 cycle while fetching PC=0x10.
  - Required next cycle: ID_inst=0x13 and ID_valid=0.
  - The following cycle, with IF_ID_write=1, resumes at the branch-target PC with ID_valid=1.
- Flush during stall: IF_ID_write=0 for 2 cycles (HOLD), then IF_flush=1 with IF_ID_write=0.
  - Required: bubble next cycle; the stale hold_q is never presented.
- Reset mid-stall: assert rst while in HOLD.
  - Required: next cycle ID_valid=0, ID_inst=0x13.
  - With IF_ID_PERF_EN defined: both perf counters read 0.
